lbus_if_param: RTL and testbench
================================

LBUS_IF_PARAM -- requirements
Module: lbus_if_param

Interface
REQ-001 SHALL have parameter KEY_W, default 128, key width in bits; multiple of 16, range 16..512.
REQ-002 SHALL have parameter DIN_W, default 128, input block width; same rules as KEY_W.
REQ-003 SHALL have parameter DOUT_W, default 128, output block width; same rules as KEY_W.
REQ-004 SHALL have parameter TRIG_DLY, default 3, cycles from start write to blk_drdy; range 1..15.
REQ-005 SHALL have parameter TMO_CYC, default 0, run timeout in cycles; 0 disables the timeout.
REQ-006 SHALL have parameter DEV_ID, default 16'h4702, value read at 0xFFFC.
REQ-007 SHALL have ports, in order:
  clk  in  1  single clock; all logic on its rising edge
  rst  in  1  synchronous, active-high reset
  lbus_a  in  16  byte address
  lbus_di  in  16  write data
  lbus_wr  in  1  write strobe, level
  lbus_rd  in  1  read strobe, active low
  lbus_do  out  16  registered read data
  blk_kin  out  KEY_W  key to core
  blk_din  out  DIN_W  data to core
  blk_dout  in  DOUT_W  result from core
  blk_krdy  out  1  key-load pulse
  blk_drdy  out  1  start pulse
  blk_kvld  in  1  key expansion done
  blk_dvld  in  1  result valid
  blk_encdec  out  1  mode
  blk_en  out  1  tied to 1
  blk_rstn  out  1  core soft reset, active low

Function
REQ-008 SHALL detect an lbus_wr rising edge through a 2-stage shift register and assert an internal write strobe (wstb) for exactly one cycle, on the cycle after the edge is detected.
REQ-009 SHALL, on wstb, decode lbus_a: 0x0002 CTRL; 0x000C encdec (bit 0); key word n at 0x0100+2n; din word n at 0x0140+2n; n < width/16; word 0 = most significant 16 bits. Other addresses are ignored.
REQ-010 CTRL write bits: [0] start, [1] key load, [2] soft reset, [3] clear status.
REQ-011 blk_krdy SHALL pulse for 1 cycle, on the cycle after a wstb with CTRL bit 1 set; key_busy sets with it and clears on blk_kvld.
REQ-012 blk_rstn SHALL be low for exactly 1 cycle after a wstb with CTRL bit 2 set. It SHALL force the FSM to IDLE and clear key_busy. Register contents are kept.
REQ-013 FSM states: IDLE, DLY, RUN.
  IDLE -> DLY on accepted start; delay counter loaded with TRIG_DLY.
  DLY decrements each cycle; blk_drdy pulses exactly TRIG_DLY cycles after the wstb cycle, then DLY -> RUN.
  RUN -> IDLE on blk_dvld, or on timeout.
REQ-014 A start in DLY or RUN SHALL be ignored and SHALL set sticky start_err.
REQ-015 Start and soft reset in the same write: soft reset wins and the start is dropped. Start and key load in the same write: both are honoured.
REQ-016 On blk_dvld in RUN: capture blk_dout into the dout register and set sticky done. blk_dvld outside RUN SHALL be ignored.
REQ-017 The latency counter SHALL clear on blk_drdy and increment each RUN cycle, saturating at 0xFFFF. Its value is frozen into LAT on RUN exit.
REQ-018 If TMO_CYC > 0 and the RUN cycle count reaches TMO_CYC, the FSM SHALL return to IDLE, set sticky tmo, and leave dout unchanged.
REQ-019 CTRL bit 3 SHALL clear done, tmo and start_err. If it coincides with setting one of these flags, the set wins.
REQ-020 Read map:
  0x0002  {busy, key_busy, ~blk_rstn}
  0x0004  {start_err, tmo, done, busy}
  0x0006  LAT
  0x000C  encdec
  0x0180+2n  dout word n
  0xFFFC  DEV_ID
  all other addresses read 0.
REQ-021 lbus_do SHALL update every cycle in which lbus_rd is low and SHALL hold while lbus_rd is high.

Reset
REQ-022 On rst high at a clk edge: lbus_do, blk_kin, blk_din, dout register, LAT, all flags, blk_encdec, blk_krdy and blk_drdy = 0; blk_rstn = 1; FSM = IDLE.
REQ-023 rst mid-operation SHALL abort the operation with no blk_drdy or blk_krdy pulse in the following cycle.

Structure
REQ-024 Package lbus_if_pkg SHALL hold the address constants, CTRL bit indices, FSM state enum and the default DEV_ID.
REQ-025 A sub-module lbus_wide_reg (parameter W; wstb/addr/base/data -> W-bit register) SHALL be instantiated once for the key and once for din.
REQ-026 An illegal width or TRIG_DLY SHALL stop elaboration with an error.

Verification
REQ-027 Write key 000102..0F and din 0x00112233..FF, then CTRL=1 -> blk_drdy exactly 3 cycles after wstb; model dvld after 10 cycles -> status=0x2, LAT=10, dout readback matches.
REQ-028 CTRL=1 while in RUN -> no second drdy; status bit 3 = 1; CTRL=8 -> status = 0.
REQ-029 TMO_CYC=20, never assert dvld -> FSM idle after 20 RUN cycles; status=0x4; dout unchanged.
REQ-030 CTRL=0x5 -> blk_rstn low 1 cycle, no drdy; CTRL=0x3 -> krdy on the next cycle and drdy TRIG_DLY cycles after wstb.
REQ-031 KEY_W=DIN_W=DOUT_W=256 -> word 15 at 0x011E maps to kin[15:0]; address 0x0120 is ignored; 0xFFFC reads 0x4702.
REQ-032 Assert rst during DLY -> no drdy; all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/lbus_if_pkg.sv
// Shared constants for the local-bus block-cipher wrapper: register map,
// CTRL bit positions, FSM encoding and parameter legality helper.
package lbus_if_pkg;

  localparam logic [15:0] ADDR_CTRL = 16'h0002;
  localparam logic [15:0] ADDR_STAT = 16'h0004;
  localparam logic [15:0] ADDR_LAT  = 16'h0006;
  localparam logic [15:0] ADDR_MODE = 16'h000C;
  localparam logic [15:0] ADDR_KEY  = 16'h0100;
  localparam logic [15:0] ADDR_DIN  = 16'h0140;
  localparam logic [15:0] ADDR_DOUT = 16'h0180;
  localparam logic [15:0] ADDR_ID   = 16'hFFFC;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_KLD   = 1;
  localparam int unsigned CTRL_SRST  = 2;
  localparam int unsigned CTRL_CLR   = 3;

  localparam logic [15:0] DEV_ID_DEF   = 16'h4702;
  localparam int unsigned TRIG_DLY_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DLY  = 2'd1,
    ST_RUN  = 2'd2
  } fsm_state_e;

  // Block widths must be whole 16-bit bus words, 16..512 bits.
  function automatic bit width_ok(input int unsigned w);
    return (w >= 16) && (w <= 512) && ((w % 16) == 0);
  endfunction

endpackage

// File: rtl/lbus_wide_reg.sv
// Wide register assembled from 16-bit bus writes; word 0 at i_base holds the
// most significant 16 bits.
module lbus_wide_reg #(
  parameter int unsigned W = 128
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_wstb,
  input  logic [15:0]  i_addr,
  input  logic [15:0]  i_base,
  input  logic [15:0]  i_data,
  output logic [W-1:0] o_q
);

  localparam int NW = int'(W / 16);

  logic [15:0] w_off;
  assign w_off = i_addr - i_base;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_q <= '0;
    end else if (i_wstb) begin
      for (int n = 0; n < NW; n++) begin
        if (w_off == 16'(2 * n)) o_q[int'(W) - 1 - 16 * n -: 16] <= i_data;
      end
    end
  end

endmodule

// File: rtl/lbus_if_param.sv
// Local-bus front end for a block-cipher core: write-edge detection, key/data
// staging, start/key-load/soft-reset control, run FSM with latency and timeout.
module lbus_if_param
  import lbus_if_pkg::*;
#(
  parameter int unsigned KEY_W    = 128,
  parameter int unsigned DIN_W    = 128,
  parameter int unsigned DOUT_W   = 128,
  parameter int unsigned TRIG_DLY = 3,
  parameter int unsigned TMO_CYC  = 0,
  parameter logic [15:0] DEV_ID   = DEV_ID_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       lbus_a,
  input  logic [15:0]       lbus_di,
  input  logic              lbus_wr,
  input  logic              lbus_rd,
  output logic [15:0]       lbus_do,
  output logic [KEY_W-1:0]  blk_kin,
  output logic [DIN_W-1:0]  blk_din,
  input  logic [DOUT_W-1:0] blk_dout,
  output logic              blk_krdy,
  output logic              blk_drdy,
  input  logic              blk_kvld,
  input  logic              blk_dvld,
  output logic              blk_encdec,
  output logic              blk_en,
  output logic              blk_rstn
);

  localparam int DOUT_NW = int'(DOUT_W / 16);

  if (!width_ok(KEY_W) || !width_ok(DIN_W) || !width_ok(DOUT_W) ||
      (TRIG_DLY < 1) || (TRIG_DLY > TRIG_DLY_MAX)) begin : g_bad_param
    $error("lbus_if_param: illegal KEY_W/DIN_W/DOUT_W or TRIG_DLY");
  end

  logic [1:0]        r_wr_sr;
  logic              r_wstb;
  fsm_state_e        r_state;
  logic [3:0]        r_dly;
  logic [15:0]       r_lat_cnt;
  logic [15:0]       r_lat;
  logic [DOUT_W-1:0] r_dout;
  logic              r_key_busy;
  logic              r_done;
  logic              r_tmo;
  logic              r_start_err;

  logic        w_ctrl_wr;
  logic        w_start;
  logic        w_kld;
  logic        w_srst;
  logic        w_clr;
  logic        w_busy;
  logic [15:0] w_lat_inc;
  logic        w_tmo_hit;
  logic [15:0] w_rd_data;

  // Soft reset in the same write suppresses the start.
  assign w_ctrl_wr = r_wstb && (lbus_a == ADDR_CTRL);
  assign w_srst    = w_ctrl_wr && lbus_di[CTRL_SRST];
  assign w_start   = w_ctrl_wr && lbus_di[CTRL_START] && !lbus_di[CTRL_SRST];
  assign w_kld     = w_ctrl_wr && lbus_di[CTRL_KLD];
  assign w_clr     = w_ctrl_wr && lbus_di[CTRL_CLR];
  assign w_busy    = (r_state != ST_IDLE);
  assign w_lat_inc = (r_lat_cnt == 16'hFFFF) ? r_lat_cnt : r_lat_cnt + 16'd1;
  assign w_tmo_hit = (TMO_CYC != 0) && (32'(w_lat_inc) >= TMO_CYC);
  assign blk_en    = 1'b1;

  lbus_wide_reg #(.W(KEY_W)) u_key (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_wstb (r_wstb),
    .i_addr (lbus_a),
    .i_base (ADDR_KEY),
    .i_data (lbus_di),
    .o_q    (blk_kin)
  );

  lbus_wide_reg #(.W(DIN_W)) u_din (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_wstb (r_wstb),
    .i_addr (lbus_a),
    .i_base (ADDR_DIN),
    .i_data (lbus_di),
    .o_q    (blk_din)
  );

  // Read-data decode.
  always_comb begin
    w_rd_data = '0;
    case (lbus_a)
      ADDR_CTRL: w_rd_data = {13'd0, w_busy, r_key_busy, ~blk_rstn};
      ADDR_STAT: w_rd_data = {12'd0, r_start_err, r_tmo, r_done, w_busy};
      ADDR_LAT:  w_rd_data = r_lat;
      ADDR_MODE: w_rd_data = {15'd0, blk_encdec};
      ADDR_ID:   w_rd_data = DEV_ID;
      default: begin
        for (int n = 0; n < DOUT_NW; n++) begin
          if (lbus_a == (ADDR_DOUT + 16'(2 * n)))
            w_rd_data = r_dout[int'(DOUT_W) - 1 - 16 * n -: 16];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_sr     <= 2'b00;
      r_wstb      <= 1'b0;
      r_state     <= ST_IDLE;
      r_dly       <= 4'd0;
      r_lat_cnt   <= 16'd0;
      r_lat       <= 16'd0;
      r_dout      <= '0;
      r_key_busy  <= 1'b0;
      r_done      <= 1'b0;
      r_tmo       <= 1'b0;
      r_start_err <= 1'b0;
      blk_krdy    <= 1'b0;
      blk_drdy    <= 1'b0;
      blk_rstn    <= 1'b1;
      blk_encdec  <= 1'b0;
      lbus_do     <= 16'd0;
    end else begin
      r_wr_sr  <= {r_wr_sr[0], lbus_wr};
      r_wstb   <= r_wr_sr[0] & ~r_wr_sr[1];
      blk_krdy <= w_kld;
      blk_drdy <= 1'b0;
      blk_rstn <= ~w_srst;

      if (r_wstb && (lbus_a == ADDR_MODE)) blk_encdec <= lbus_di[0];
      if (!lbus_rd) lbus_do <= w_rd_data;

      if (blk_kvld || w_srst) r_key_busy <= 1'b0;
      if (w_kld)              r_key_busy <= 1'b1;

      // Clear first so a coincident set below takes priority.
      if (w_clr) begin
        r_done      <= 1'b0;
        r_tmo       <= 1'b0;
        r_start_err <= 1'b0;
      end
      if (w_start && w_busy) r_start_err <= 1'b1;

      if (w_srst) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start) begin
              if (TRIG_DLY == 1) begin
                blk_drdy  <= 1'b1;
                r_lat_cnt <= 16'd0;
                r_state   <= ST_RUN;
              end else begin
                r_dly   <= 4'(TRIG_DLY - 1);
                r_state <= ST_DLY;
              end
            end
          end
          ST_DLY: begin
            if (r_dly == 4'd1) begin
              blk_drdy  <= 1'b1;
              r_lat_cnt <= 16'd0;
              r_state   <= ST_RUN;
            end else begin
              r_dly <= r_dly - 4'd1;
            end
          end
          ST_RUN: begin
            if (blk_dvld) begin
              r_dout  <= blk_dout;
              r_done  <= 1'b1;
              r_lat   <= r_lat_cnt;
              r_state <= ST_IDLE;
            end else if (w_tmo_hit) begin
              r_tmo   <= 1'b1;
              r_lat   <= w_lat_inc;
              r_state <= ST_IDLE;
            end else begin
              r_lat_cnt <= w_lat_inc;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lbus_if_param.sv
// Directed bench: 128-bit instance with a 20-cycle timeout (A) and a 256-bit
// instance (B) sharing one local bus.
module tb_lbus_if_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] lbus_a, lbus_di;
  logic        lbus_wr, lbus_rd;

  logic [15:0]  a_do, b_do;
  logic [127:0] a_kin, a_din, a_dout_in;
  logic [255:0] b_kin, b_din, b_dout_in;
  logic a_krdy, a_drdy, a_kvld, a_dvld, a_encdec, a_en, a_rstn;
  logic b_krdy, b_drdy, b_encdec, b_en, b_rstn;
  logic b_kvld, b_dvld;

  lbus_if_param #(.TMO_CYC(20)) dut_a (
    .clk(clk), .rst(rst), .lbus_a(lbus_a), .lbus_di(lbus_di), .lbus_wr(lbus_wr),
    .lbus_rd(lbus_rd), .lbus_do(a_do), .blk_kin(a_kin), .blk_din(a_din),
    .blk_dout(a_dout_in), .blk_krdy(a_krdy), .blk_drdy(a_drdy), .blk_kvld(a_kvld),
    .blk_dvld(a_dvld), .blk_encdec(a_encdec), .blk_en(a_en), .blk_rstn(a_rstn)
  );

  lbus_if_param #(.KEY_W(256), .DIN_W(256), .DOUT_W(256)) dut_b (
    .clk(clk), .rst(rst), .lbus_a(lbus_a), .lbus_di(lbus_di), .lbus_wr(lbus_wr),
    .lbus_rd(lbus_rd), .lbus_do(b_do), .blk_kin(b_kin), .blk_din(b_din),
    .blk_dout(b_dout_in), .blk_krdy(b_krdy), .blk_drdy(b_drdy), .blk_kvld(b_kvld),
    .blk_dvld(b_dvld), .blk_encdec(b_encdec), .blk_en(b_en), .blk_rstn(b_rstn)
  );

  localparam logic [127:0] KEY = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] DIN = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] V1  = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] V2  = 128'hDEADBEEFCAFEF00D13579BDF2468ACE0;
  localparam logic [127:0] V3  = 128'h5555AAAA5555AAAA5555AAAA5555AAAA;

  int n_cmp  = 0;
  int n_fail = 0;
  int drdy_cnt = 0;
  int cnt0;
  logic [127:0] vtmp;

  always @(negedge clk) if (a_drdy === 1'b1) drdy_cnt++;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the negedge of the cycle after the internal write strobe.
  task automatic bus_wr(input logic [15:0] addr, input logic [15:0] data);
    lbus_wr = 1'b0;
    lbus_a  = addr;
    lbus_di = data;
    tick(1);
    lbus_wr = 1'b1;
    tick(3);
    lbus_wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] addr);
    lbus_a  = addr;
    lbus_rd = 1'b0;
    tick(1);
    lbus_rd = 1'b1;
  endtask

  initial begin
    rst = 1'b1; lbus_a = '0; lbus_di = '0; lbus_wr = 1'b0; lbus_rd = 1'b1;
    a_kvld = 1'b0; a_dvld = 1'b0; a_dout_in = '0;
    b_kvld = 1'b0; b_dvld = 1'b0; b_dout_in = '0;
    tick(3);
    chk("rst_ctl_bits", 256'({a_krdy, a_drdy, a_rstn, a_encdec, a_en}), 256'(5'b00101));
    chk("rst_kin", 256'(a_kin), 256'(0));
    chk("rst_do", 256'(a_do), 256'(0));
    rst = 1'b0;
    tick(1);

    for (int i = 0; i < 8; i++) begin
      bus_wr(16'h0100 + 16'(2 * i), {8'(2 * i), 8'(2 * i + 1)});
      bus_wr(16'h0140 + 16'(2 * i), {8'(34 * i), 8'(34 * i + 17)});
    end
    chk("key_reg", 256'(a_kin), 256'(KEY));
    chk("din_reg", 256'(a_din), 256'(DIN));

    bus_wr(16'h000C, 16'h0001);
    chk("encdec_out", 256'(a_encdec), 256'(1'b1));
    bus_rd(16'h000C);
    chk("encdec_rd", 256'(a_do), 256'(16'h0001));

    // Normal run: drdy three cycles after wstb, dvld ten cycles after drdy.
    cnt0 = drdy_cnt;
    a_dout_in = V1;
    bus_wr(16'h0002, 16'h0001);
    chk("start_krdy", 256'(a_krdy), 256'(1'b0));
    chk("drdy_c1", 256'(a_drdy), 256'(1'b0));
    tick(1);
    chk("drdy_c2", 256'(a_drdy), 256'(1'b0));
    tick(1);
    chk("drdy_c3", 256'(a_drdy), 256'(1'b1));
    tick(10);
    a_dvld = 1'b1;
    tick(1);
    a_dvld = 1'b0;
    bus_rd(16'h0004);
    chk("stat_done", 256'(a_do), 256'(16'h0002));
    bus_rd(16'h0006);
    chk("lat_10", 256'(a_do), 256'(16'd10));
    vtmp = V1;
    for (int i = 0; i < 8; i++) begin
      bus_rd(16'h0180 + 16'(2 * i));
      chk($sformatf("dout_w%0d", i), 256'(a_do), 256'(vtmp[127 - 16 * i -: 16]));
    end
    chk("drdy_once", 256'(drdy_cnt - cnt0), 256'(1));

    // Start while running: ignored, flags start_err.
    cnt0 = drdy_cnt;
    bus_wr(16'h0002, 16'h0001);
    tick(2);
    bus_wr(16'h0002, 16'h0001);
    tick(2);
    bus_rd(16'h0004);
    chk("stat_start_err", 256'(a_do), 256'(16'h000B));
    chk("no_2nd_drdy", 256'(drdy_cnt - cnt0), 256'(1));
    a_dout_in = V2;
    a_dvld = 1'b1;
    tick(1);
    a_dvld = 1'b0;
    bus_rd(16'h0004);
    chk("stat_after_run", 256'(a_do), 256'(16'h000A));
    bus_wr(16'h0002, 16'h0008);
    bus_rd(16'h0004);
    chk("stat_cleared", 256'(a_do), 256'(16'h0000));

    // Timeout: exactly 20 RUN cycles, dout keeps V2.
    cnt0 = drdy_cnt;
    a_dout_in = V3;
    bus_wr(16'h0002, 16'h0001);
    tick(21);
    bus_rd(16'h0004);
    chk("tmo_last_run", 256'(a_do), 256'(16'h0001));
    bus_rd(16'h0004);
    chk("tmo_stat", 256'(a_do), 256'(16'h0004));
    bus_rd(16'h0006);
    chk("tmo_lat", 256'(a_do), 256'(16'd20));
    bus_rd(16'h0180);
    chk("tmo_dout_w0", 256'(a_do), 256'(16'hDEAD));
    bus_rd(16'h018E);
    chk("tmo_dout_w7", 256'(a_do), 256'(16'hACE0));
    chk("tmo_drdy", 256'(drdy_cnt - cnt0), 256'(1));
    bus_wr(16'h0002, 16'h0008);

    // Soft reset beats start; start plus key load both honoured.
    cnt0 = drdy_cnt;
    bus_wr(16'h0002, 16'h0005);
    chk("srst_rstn_low", 256'(a_rstn), 256'(1'b0));
    tick(1);
    chk("srst_rstn_high", 256'(a_rstn), 256'(1'b1));
    tick(4);
    chk("srst_no_drdy", 256'(drdy_cnt - cnt0), 256'(0));
    bus_wr(16'h0002, 16'h0003);
    chk("kld_krdy", 256'({a_krdy, a_drdy}), 256'(2'b10));
    tick(1);
    chk("kld_krdy_end", 256'({a_krdy, a_drdy}), 256'(2'b00));
    tick(1);
    chk("kld_drdy", 256'(a_drdy), 256'(1'b1));
    bus_rd(16'h0002);
    chk("ctrl_busy_kbusy", 256'(a_do), 256'(16'h0006));
    a_kvld = 1'b1;
    tick(1);
    a_kvld = 1'b0;
    a_dvld = 1'b1;
    tick(1);
    a_dvld = 1'b0;
    bus_rd(16'h0002);
    chk("ctrl_idle", 256'(a_do), 256'(16'h0000));

    // Wide instance addressing and out-of-range words.
    bus_wr(16'h011E, 16'hBEEF);
    chk("b_kin_w15", 256'(b_kin), {KEY, 112'd0, 16'hBEEF});
    chk("a_kin_w15_ign", 256'(a_kin), 256'(KEY));
    bus_wr(16'h0120, 16'h1234);
    chk("b_kin_0120_ign", 256'(b_kin), {KEY, 112'd0, 16'hBEEF});
    bus_rd(16'hFFFC);
    chk("b_dev_id", 256'(b_do), 256'(16'h4702));
    chk("a_dev_id", 256'(a_do), 256'(16'h4702));
    lbus_a = 16'h0004;
    tick(2);
    chk("do_hold", 256'(a_do), 256'(16'h4702));
    bus_rd(16'h0008);
    chk("unmapped_rd", 256'(a_do), 256'(16'h0000));

    // Reset during DLY aborts without a drdy pulse.
    cnt0 = drdy_cnt;
    bus_rd(16'hFFFC);
    bus_wr(16'h0002, 16'h0001);
    rst = 1'b1;
    tick(1);
    chk("rst_dly_bits", 256'({a_krdy, a_drdy, a_rstn, a_encdec, a_en}), 256'(5'b00101));
    chk("rst_dly_kin", 256'(a_kin), 256'(0));
    chk("rst_dly_din", 256'(a_din), 256'(0));
    chk("rst_dly_do", 256'(a_do), 256'(0));
    rst = 1'b0;
    tick(5);
    chk("rst_dly_no_drdy", 256'(drdy_cnt - cnt0), 256'(0));
    bus_rd(16'h0004);
    chk("rst_dly_stat", 256'(a_do), 256'(16'h0000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
